// File: rtl/timer_time_editor.sv
// Debounced four-button BCD time editor feeding the count-down timer's set port.
// Optional auto-repeat of held up/down steps is built only when AUTO_REPEAT_EN is defined.
module timer_time_editor #(
  parameter int DEB_CYCLES          = 100000,
  parameter int REPEAT_DELAY_CYCLES = 2500000,
  parameter int REPEAT_RATE_CYCLES  = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_confirm,
  output logic [7:0] hour_bcd_out,
  output logic [7:0] minute_bcd_out,
  output logic [7:0] second_bcd_out,
  output logic       set_pulse,
  output logic       editing,
  output logic [1:0] field_sel
);

  typedef enum logic [2:0] {S_IDLE, S_EDIT_HOUR, S_EDIT_MIN, S_EDIT_SEC, S_COMMIT} state_t;

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int B_MODE = 0, B_UP = 1, B_DOWN = 2, B_CONFIRM = 3;

  state_t        r_state, w_state_next;
  logic [3:0]    w_btn_raw;
  logic [3:0]    r_sync1, r_sync2, r_level, r_level_d, r_press;
  logic [DW-1:0] r_deb_cnt [4];
  logic [7:0]    r_hour, r_min, r_sec;
  logic          w_in_edit, w_rep_up, w_rep_down, w_up_evt, w_down_evt;
  logic          w_step_up, w_step_down;

  assign w_btn_raw = {btn_confirm, btn_down, btn_up, btn_mode};

  // NOTE: the debounce counters are plain flops, not RAM, so they clear with rst like any other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_level   <= '0;
      r_level_d <= '0;
      r_press   <= '0;
      for (int i = 0; i < 4; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1   <= w_btn_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] != r_level[i]) begin
          if (r_deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
            r_level[i]   <= r_sync2[i];
            r_deb_cnt[i] <= '0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
          end
        end else begin
          r_deb_cnt[i] <= '0;
        end
      end
    end
  end

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
    if (v == vmax)             return 8'h00;
    else if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    else                       return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
    if (v == 8'h00)            return vmax;
    else if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'd9};
    else                       return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign w_in_edit = (r_state == S_EDIT_HOUR) || (r_state == S_EDIT_MIN) || (r_state == S_EDIT_SEC);

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ? REPEAT_DELAY_CYCLES
                                                                   : REPEAT_RATE_CYCLES;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_phase;
  logic          w_hold, w_rep_tick;

  // Hold timing is aligned to the press step, so the first repeat lands DELAY cycles after it.
  assign w_hold     = w_in_edit && (r_level_d[B_UP] ^ r_level_d[B_DOWN]) && (w_state_next == r_state);
  assign w_rep_tick = w_hold && (r_rep_cnt == (r_rep_phase ? RW'(REPEAT_RATE_CYCLES)
                                                           : RW'(REPEAT_DELAY_CYCLES)));
  assign w_rep_up   = w_rep_tick & r_level_d[B_UP];
  assign w_rep_down = w_rep_tick & r_level_d[B_DOWN];

  always_ff @(posedge clk) begin
    if (rst || !w_hold) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_rep_tick) begin
      r_rep_cnt   <= RW'(1);
      r_rep_phase <= 1'b1;
    end else begin
      r_rep_cnt   <= r_rep_cnt + 1'b1;
    end
  end
`else
  assign w_rep_up   = 1'b0;
  assign w_rep_down = 1'b0;
  // Repeat timing has no hardware in this build; the empty block only keeps the parameters referenced.
  if (REPEAT_DELAY_CYCLES > 0 && REPEAT_RATE_CYCLES > 0) begin : g_no_repeat
  end
`endif

  assign w_up_evt    = r_press[B_UP] | w_rep_up;
  assign w_down_evt  = r_press[B_DOWN] | w_rep_down;
  assign w_step_up   = w_in_edit & w_up_evt & ~w_down_evt;
  assign w_step_down = w_in_edit & w_down_evt & ~w_up_evt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Confirm outranks mode so a simultaneous press always commits.
  always_comb begin
    w_state_next = r_state;
    editing      = 1'b0;
    field_sel    = 2'd0;
    set_pulse    = 1'b0;
    case (r_state)
      S_IDLE: if (r_press[B_MODE]) w_state_next = S_EDIT_HOUR;
      S_EDIT_HOUR: begin
        editing   = 1'b1;
        field_sel = 2'd1;
        if (r_press[B_CONFIRM])   w_state_next = S_COMMIT;
        else if (r_press[B_MODE]) w_state_next = S_EDIT_MIN;
      end
      S_EDIT_MIN: begin
        editing   = 1'b1;
        field_sel = 2'd2;
        if (r_press[B_CONFIRM])   w_state_next = S_COMMIT;
        else if (r_press[B_MODE]) w_state_next = S_EDIT_SEC;
      end
      S_EDIT_SEC: begin
        editing   = 1'b1;
        field_sel = 2'd3;
        if (r_press[B_CONFIRM])   w_state_next = S_COMMIT;
        else if (r_press[B_MODE]) w_state_next = S_EDIT_HOUR;
      end
      S_COMMIT: begin
        set_pulse    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hour <= 8'h00;
      r_min  <= 8'h00;
      r_sec  <= 8'h00;
    end else begin
      case (r_state)
        S_EDIT_HOUR: begin
          if (w_step_up)        r_hour <= bcd_inc(r_hour, 8'h23);
          else if (w_step_down) r_hour <= bcd_dec(r_hour, 8'h23);
        end
        S_EDIT_MIN: begin
          if (w_step_up)        r_min <= bcd_inc(r_min, 8'h59);
          else if (w_step_down) r_min <= bcd_dec(r_min, 8'h59);
        end
        S_EDIT_SEC: begin
          if (w_step_up)        r_sec <= bcd_inc(r_sec, 8'h59);
          else if (w_step_down) r_sec <= bcd_dec(r_sec, 8'h59);
        end
        default: ;
      endcase
    end
  end

  assign hour_bcd_out   = r_hour;
  assign minute_bcd_out = r_min;
  assign second_bcd_out = r_sec;

endmodule

// File: tb/tb_timer_time_editor.sv
// Directed self-checking bench for timer_time_editor (DEB=4, DELAY=20, RATE=5).
// Expected auto-repeat result depends on whether AUTO_REPEAT_EN is defined for the build.
module tb_timer_time_editor;

  localparam int DEB   = 4;
  localparam int DELAY = 20;
  localparam int RATE  = 5;
  localparam int SETTLE = DEB + 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_confirm = 1'b0;
  logic [7:0] hour_bcd_out, minute_bcd_out, second_bcd_out;
  logic       set_pulse, editing;
  logic [1:0] field_sel;

  int n_checks = 0;
  int n_pass   = 0;
  int sp_count = 0;
  int bad_digits = 0;

  timer_time_editor #(
    .DEB_CYCLES(DEB),
    .REPEAT_DELAY_CYCLES(DELAY),
    .REPEAT_RATE_CYCLES(RATE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_mode(btn_mode),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_confirm(btn_confirm),
    .hour_bcd_out(hour_bcd_out),
    .minute_bcd_out(minute_bcd_out),
    .second_bcd_out(second_bcd_out),
    .set_pulse(set_pulse),
    .editing(editing),
    .field_sel(field_sel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (set_pulse === 1'b1) sp_count <= sp_count + 1;

  always @(negedge clk)
    if (hour_bcd_out[3:0] > 4'd9 || hour_bcd_out[7:4] > 4'd9 ||
        minute_bcd_out[3:0] > 4'd9 || minute_bcd_out[7:4] > 4'd9 ||
        second_bcd_out[3:0] > 4'd9 || second_bcd_out[7:4] > 4'd9)
      bad_digits <= bad_digits + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mask bits: {confirm, down, up, mode}
  task automatic drive(input logic [3:0] m);
    {btn_confirm, btn_down, btn_up, btn_mode} = m;
  endtask

  task automatic press(input logic [3:0] m, input int n = 1);
    repeat (n) begin
      drive(m);
      tick(SETTLE);
      drive(4'b0000);
      tick(SETTLE);
    end
  endtask

  task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] mi,
                            input logic [7:0] s);
    check({tag, " hour"}, hour_bcd_out, h);
    check({tag, " min"},  minute_bcd_out, mi);
    check({tag, " sec"},  second_bcd_out, s);
  endtask

  task automatic commit(input logic [3:0] m, input string tag, input logic [7:0] h,
                        input logic [7:0] mi, input logic [7:0] s);
    bit seen = 1'b0;
    drive(m);
    for (int i = 0; i < DEB + 10 && !seen; i++) begin
      @(negedge clk);
      if (set_pulse === 1'b1) seen = 1'b1;
    end
    check({tag, " set_pulse seen"}, seen, 1);
    check_time(tag, h, mi, s);
    tick(1);
    check({tag, " set_pulse width"}, set_pulse, 0);
    check({tag, " editing after"}, editing, 0);
    check({tag, " field_sel after"}, field_sel, 0);
    drive(4'b0000);
    tick(SETTLE);
  endtask

  initial begin
    int sp_before;
    bit seen;

    rst = 1'b1;
    tick(2);
    check_time("reset", 8'h00, 8'h00, 8'h00);
    check("reset field_sel", field_sel, 0);
    check("reset editing", editing, 0);
    check("reset set_pulse", set_pulse, 0);
    rst = 1'b0;
    tick(2);

    press(4'b0001);
    check("enter edit", editing, 1);
    check("field hour", field_sel, 1);
    press(4'b0010, 3);
    check("hour up x3", hour_bcd_out, 8'h03);
    press(4'b0001);
    check("field min", field_sel, 2);
    press(4'b0100);
    check("min 00 down", minute_bcd_out, 8'h59);
    press(4'b0001);
    check("field sec", field_sel, 3);
    press(4'b0010, 2);
    commit(4'b1000, "edit seq", 8'h03, 8'h59, 8'h02);

    press(4'b0010);
    check("idle up ignored", hour_bcd_out, 8'h03);
    check("idle stays idle", editing, 0);

    press(4'b0001);
    press(4'b0100, 3);
    check("hour down to 00", hour_bcd_out, 8'h00);
    press(4'b0100);
    check("hour 00 down", hour_bcd_out, 8'h23);
    press(4'b0010);
    check("hour 23 up", hour_bcd_out, 8'h00);
    press(4'b0100);
    press(4'b0001);
    press(4'b0010);
    check("min 59 up", minute_bcd_out, 8'h00);
    press(4'b0001);
    press(4'b0100, 2);
    check("sec down to 00", second_bcd_out, 8'h00);
    press(4'b0100);
    check("sec 00 down", second_bcd_out, 8'h59);

    drive(4'b0010);
    tick(DEB - 1);
    drive(4'b0000);
    tick(SETTLE);
    check("bounce short", second_bcd_out, 8'h59);

    press(4'b0110);
    check_time("up+down", 8'h23, 8'h00, 8'h59);

    commit(4'b1001, "mode+confirm", 8'h23, 8'h00, 8'h59);

    press(4'b0001);
    commit(4'b1010, "confirm+up", 8'h00, 8'h00, 8'h59);

    press(4'b0001);
    press(4'b0010, 12);
    press(4'b0001);
    press(4'b0010, 34);
    press(4'b0001);
    press(4'b0010);
    press(4'b0001, 2);
    check_time("pre-reset", 8'h12, 8'h34, 8'h00);
    check("pre-reset field", field_sel, 2);

    sp_before = sp_count;
    rst = 1'b1;
    tick(2);
    check_time("reset mid-edit", 8'h00, 8'h00, 8'h00);
    check("reset mid-edit field", field_sel, 0);
    check("reset mid-edit editing", editing, 0);
    rst = 1'b0;
    tick(2);
    check("reset no set_pulse", sp_count, sp_before);

    press(4'b0001, 3);
    check("repeat field sec", field_sel, 3);
    drive(4'b0010);
    seen = 1'b0;
    for (int i = 0; i < DEB + 10 && !seen; i++) begin
      @(negedge clk);
      if (second_bcd_out === 8'h01) seen = 1'b1;
    end
    check("repeat first step", seen, 1);
    tick(DELAY + 3 * RATE - 2);
`ifdef AUTO_REPEAT_EN
    check("repeat hold", second_bcd_out, 8'h04);
`else
    check("repeat hold", second_bcd_out, 8'h01);
`endif
    drive(4'b0000);
    tick(SETTLE);

    check("digits never above 9", bad_digits, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_time_editor.md
Name: timer_time_editor

Overview:
Upstream front-end for the count-down timer. It turns four raw push-buttons into a debounced, field-by-field BCD time editor. It drives hour/minute/second BCD values and a one-cycle set strobe straight into the timer's BCD inputs and set input. It also exports edit status so the display can blink the selected field.

Parameters:
DEB_CYCLES, 100000, consecutive stable cycles before a button level is accepted (20 ms at 5 MHz).
REPEAT_DELAY_CYCLES, 2500000, hold time before auto-repeat starts (used only with AUTO_REPEAT_EN).
REPEAT_RATE_CYCLES, 500000, auto-repeat step period (used only with AUTO_REPEAT_EN).

Ports:
clk  in  1  system clock (5 MHz)
rst  in  1  reset: synchronous, active-high
btn_mode  in  1  raw button, async, active-high; enter edit / next field
btn_up  in  1  raw button; increment selected field
btn_down  in  1  raw button; decrement selected field
btn_confirm  in  1  raw button; commit edited time
hour_bcd_out  out  8  working hours, BCD 00-23
minute_bcd_out  out  8  working minutes, BCD 00-59
second_bcd_out  out  8  working seconds, BCD 00-59
set_pulse  out  1  one-cycle commit strobe to the timer's set input
editing  out  1  high while in any EDIT state
field_sel  out  2  0=none, 1=hour, 2=minute, 3=second

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, all BCD outputs 8'h00, set_pulse 0, editing 0, field_sel 0. Debouncer levels and counters are cleared to 0.
- Per-button input path:
  - 2-FF synchroniser.
  - Debounced level toggles only after the synchronised input differs from it for DEB_CYCLES consecutive cycles. Any mismatch gap restarts the count.
  - One-cycle press pulse is generated on the debounced rising edge. Release produces no pulse.
- FSM states: IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT.
  - IDLE: mode pulse -> EDIT_HOUR. Up, down and confirm pulses are ignored.
  - EDIT_HOUR -> EDIT_MIN -> EDIT_SEC -> EDIT_HOUR on each mode pulse.
  - EDIT_*: confirm pulse -> COMMIT.
  - COMMIT: lasts exactly 1 cycle with set_pulse=1, then unconditionally -> IDLE.
- editing = 1 in the EDIT_* states. field_sel tracks the state: IDLE and COMMIT give 0.
- Field arithmetic is BCD; the value updates on the cycle after the press pulse.
  - Hours wrap 23 -> 00 on up and 00 -> 23 on down.
  - Minutes and seconds wrap 59 -> 00 and 00 -> 59.
  - Each digit always stays 0-9; no binary intermediate appears on the outputs.
- Outputs are the live working registers and change during editing. The timer only samples them on set_pulse. Values persist after commit and are the starting point for the next edit.
- Simultaneous events in the same cycle:
  - Up and down together: both ignored.
  - Confirm and mode together: confirm wins.
  - Confirm and up/down together: the step is applied and COMMIT is entered. set_pulse then carries the stepped value.
- rst mid-edit or in COMMIT: immediate return to reset values; no set_pulse is emitted.
- Latency: a raw press held stable gives its press pulse DEB_CYCLES+3 cycles after the raw rise (2 synchroniser stages, the debounce count, 1 edge-detect stage).

Optional Feature:
AUTO_REPEAT_EN.
- Defined: when up or down is held debounced-high in an EDIT state, a further step fires after REPEAT_DELAY_CYCLES, then every REPEAT_RATE_CYCLES until release or a state change. The hold counter clears on release.
- Undefined: exactly one step per press; no repeat counters are synthesised.

Test Plan:
- Reset (DEB_CYCLES=4): assert rst for 2 cycles -> outputs 00:00:00, field_sel=0, editing=0, set_pulse=0.
- Edit sequence: mode, up x3, mode, down x1, mode, up x2, confirm -> set_pulse high exactly 1 cycle with outputs 03:59:02; afterwards editing=0 and field_sel=0.
- Wrap checks:
  - Hour 23 + up -> 00; hour 00 + down -> 23.
  - Minute 59 + up -> 00.
  - Second 00 + down -> 59.
  - No digit ever exceeds 9.
- Bounce and collisions:
  - btn_up high for DEB_CYCLES-1 cycles, then low -> no change.
  - up+down pulses in the same cycle -> no change.
  - mode+confirm in the same cycle -> COMMIT.
- Reset during EDIT_MIN with value 12:34:00 -> 00:00:00 and IDLE; set_pulse stays 0.
- Auto-repeat (DEB=4, DELAY=20, RATE=5): hold up in EDIT_SEC for DELAY+3*RATE cycles after the debounce pulse -> seconds=04 with AUTO_REPEAT_EN, seconds=01 without.
